// File: rtl/lift_pkg.sv
// Shared definitions for the hall-call scheduler: default sizing constants
// and the three-state issue FSM encoding.
package lift_pkg;

  localparam int NUM_FLOORS_DEF = 10;
  localparam int FLOOR_W_DEF    = 4;

  // Width of the dwell down-counter; it covers a dwell length of up to 255.
  localparam int DWELL_CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    DWELL = 2'd2
  } lift_state_t;

endpackage

// File: rtl/rr_floor_picker.sv
// Purely combinational round-robin floor selector. The search starts at
// the floor after last_served and wraps from NUM_FLOORS back to floor 1;
// the first pending floor met on that walk is selected.
module rr_floor_picker
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    last_served,
  output logic [FLOOR_W-1:0]    sel_floor,
  output logic                  any_pending
);

  // w_cand[gi] is the floor visited at search position gi (position 0 is
  // the floor right after last_served); w_hit[gi] says it is pending.
  logic [FLOOR_W-1:0]    w_cand [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] w_hit;

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_cand
    logic [FLOOR_W:0] w_sum;

    // last_served + offset never exceeds 2*NUM_FLOORS, so a single
    // conditional subtraction is enough to wrap back into 1..NUM_FLOORS.
    assign w_sum       = {1'b0, last_served} + (FLOOR_W+1)'(gi + 1);
    assign w_cand[gi]  = (w_sum > (FLOOR_W+1)'(NUM_FLOORS))
                         ? FLOOR_W'(w_sum - (FLOOR_W+1)'(NUM_FLOORS))
                         : FLOOR_W'(w_sum);
    assign w_hit[gi]   = pending[w_cand[gi] - 1'b1];
  end

  assign any_pending = |pending;

  // Priority walk: scanning from the far end lets the nearest hit win.
  always_comb begin
    sel_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        sel_floor = w_cand[i];
      end
    end
  end

endmodule

// File: rtl/hall_call_scheduler.sv
// Hall-call scheduler: latches hall buttons into a pending bitmap and issues
// them one at a time, round-robin, to a downstream lift controller over a
// valid/ready handshake, with a fixed dwell after every accepted call.
// Optional feature macro: CALL_COUNT_EN adds a saturating 16-bit
// call_count output counting accepted handshakes.
module hall_call_scheduler
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
  parameter int FLOOR_W      = FLOOR_W_DEF,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  output logic [FLOOR_W-1:0]    floor_out,
  output logic                  floor_valid,
  input  logic                  floor_ready,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
`ifdef CALL_COUNT_EN
  ,
  output logic [15:0]           call_count
`endif
);

  lift_state_t            r_state;
  lift_state_t            w_state_next;
  logic [NUM_FLOORS-1:0]  r_pending;
  logic [NUM_FLOORS-1:0]  w_clr_mask;
  logic [FLOOR_W-1:0]     r_floor_out;
  logic [FLOOR_W-1:0]     w_floor_next;
  logic                   r_floor_valid;
  logic                   w_valid_next;
  logic [FLOOR_W-1:0]     r_last_served;
  logic [FLOOR_W-1:0]     w_last_next;
  logic [DWELL_CNT_W-1:0] r_dwell_cnt;
  logic [DWELL_CNT_W-1:0] w_dwell_next;
  logic                   w_accept;
  logic [FLOOR_W-1:0]     w_sel;
  logic                   w_any;

  // The picker only ever looks at the registered bitmap, so a button
  // pressed on this edge is considered from the next IDLE edge onwards.
  rr_floor_picker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_picker (
    .pending     (r_pending),
    .last_served (r_last_served),
    .sel_floor   (w_sel),
    .any_pending (w_any)
  );

  // One-hot clear mask for the floor being accepted on this edge.
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_clr
    assign w_clr_mask[gi] = w_accept && (r_floor_out == FLOOR_W'(gi + 1));
  end

  // Next-state and datapath decisions of the issue FSM.
  always_comb begin
    w_state_next = r_state;
    w_floor_next = r_floor_out;
    w_valid_next = r_floor_valid;
    w_last_next  = r_last_served;
    w_dwell_next = r_dwell_cnt;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next = OFFER;
          w_floor_next = w_sel;
          w_valid_next = 1'b1;
        end
      end
      OFFER: begin
        // floor_out and floor_valid simply hold until the handshake.
        if (floor_ready) begin
          w_accept     = 1'b1;
          w_last_next  = r_floor_out;
          w_valid_next = 1'b0;
          w_state_next = DWELL;
          w_dwell_next = DWELL_CNT_W'(DWELL_CYCLES - 1);
        end
      end
      DWELL: begin
        // Counter starts at DWELL_CYCLES-1, giving DWELL_CYCLES cycles here.
        if (r_dwell_cnt == '0) begin
          w_state_next = IDLE;
        end else begin
          w_dwell_next = r_dwell_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_valid_next = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Offer datapath, round-robin pointer and dwell counter. last_served
  // resets to the top floor so the first search begins at floor 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_floor_out   <= '0;
      r_floor_valid <= 1'b0;
      r_last_served <= FLOOR_W'(NUM_FLOORS);
      r_dwell_cnt   <= '0;
    end else begin
      r_floor_out   <= w_floor_next;
      r_floor_valid <= w_valid_next;
      r_last_served <= w_last_next;
      r_dwell_cnt   <= w_dwell_next;
    end
  end

  // Pending bitmap: the clear is applied first, so a press on the
  // accepting edge keeps its bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | call_btn;
    end
  end

`ifdef CALL_COUNT_EN
  logic [15:0] r_call_count;

  // Saturating count of accepted handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_call_count <= '0;
    end else if (w_accept && (r_call_count != 16'hFFFF)) begin
      r_call_count <= r_call_count + 16'd1;
    end
  end

  assign call_count = r_call_count;
`endif

  assign floor_out   = r_floor_out;
  assign floor_valid = r_floor_valid;
  assign pending     = r_pending;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_hall_call_scheduler.sv
// Self-checking bench for hall_call_scheduler: directed scenarios with
// hand-computed expectations, then randomized traffic checked every cycle
// against a behavioural model of the issue rules.
module tb_hall_call_scheduler;

  localparam int NF = 10;
  localparam int FW = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] call_btn = '0;
  logic          floor_ready = 1'b0;
  logic [FW-1:0] floor_out;
  logic          floor_valid;
  logic [NF-1:0] pending;
  logic          busy;
`ifdef CALL_COUNT_EN
  logic [15:0]   call_count;
`endif

  hall_call_scheduler #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .DWELL_CYCLES (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .call_btn    (call_btn),
    .floor_out   (floor_out),
    .floor_valid (floor_valid),
    .floor_ready (floor_ready),
    .pending     (pending),
    .busy        (busy)
`ifdef CALL_COUNT_EN
    ,
    .call_count  (call_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Behavioural model: set of outstanding floors, the floor currently on
  // offer (0 = none), last floor served and the cycles left before the
  // scheduler may offer again.
  bit m_pend [1:NF];
  int m_last;
  int m_offer;
  int m_gap;
  int m_cnt;

  int iss_floor [$];
  int iss_cyc   [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick();
    for (int k = 1; k <= NF; k++) begin
      int f;
      f = ((m_last - 1 + k) % NF) + 1;
      if (m_pend[f]) return f;
    end
    return 0;
  endfunction

  function automatic logic [NF-1:0] exp_pend();
    logic [NF-1:0] v;
    v = '0;
    for (int f = 1; f <= NF; f++) v[f-1] = m_pend[f];
    return v;
  endfunction

  task automatic model_reset();
    for (int f = 1; f <= NF; f++) m_pend[f] = 1'b0;
    m_last  = NF;
    m_offer = 0;
    m_gap   = 0;
    m_cnt   = 0;
  endtask

  // One rising edge of the model, using the inputs present at that edge.
  task automatic model_step(input logic [NF-1:0] btn, input logic rdy);
    if (m_offer != 0) begin
      if (rdy) begin
        m_pend[m_offer] = 1'b0;
        m_last  = m_offer;
        m_offer = 0;
        m_gap   = DW;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      m_offer = pick();
    end
    for (int f = 1; f <= NF; f++) if (btn[f-1]) m_pend[f] = 1'b1;
  endtask

  // Advance one clock: model follows the edge, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(call_btn, floor_ready);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    call_btn = '0;
    floor_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!floor_valid && n < max) begin
      tick();
      n++;
    end
    check("wait_valid_timeout", {31'd0, floor_valid}, 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Per-cycle compare against the model plus an issue log.
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      check("cmp_valid", {31'd0, floor_valid}, {31'd0, m_offer != 0});
      if (m_offer != 0) check("cmp_floor_out", {28'd0, floor_out}, m_offer);
      if (floor_valid) check("cmp_out_nonzero", {31'd0, floor_out != '0}, 32'd1);
      check("cmp_pending", {22'd0, pending}, {22'd0, exp_pend()});
      check("cmp_busy", {31'd0, busy}, {31'd0, (m_offer != 0) || (m_gap > 0)});
`ifdef CALL_COUNT_EN
      check("cmp_call_count", {16'd0, call_count}, m_cnt);
`endif
      if (floor_valid && !prev_v) begin
        iss_floor.push_back(int'(floor_out));
        iss_cyc.push_back(cyc);
        $display("issue floor %0d at cycle %0d", floor_out, cyc);
      end
      prev_v = floor_valid;
    end
  end

  initial begin
    int n;
    int t0;

    // ---- reset state and single call (floor 4) ----
    do_reset();
    check("rst_floor_out", {28'd0, floor_out}, 32'd0);
    check("rst_valid", {31'd0, floor_valid}, 32'd0);
    check("rst_pending", {22'd0, pending}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    call_btn = '0; call_btn[3] = 1'b1; floor_ready = 1'b1;
    tick();
    check("A_pend4_set", {31'd0, pending[3]}, 32'd1);
    check("A_valid_early", {31'd0, floor_valid}, 32'd0);
    call_btn = '0;
    tick();
    check("A_valid", {31'd0, floor_valid}, 32'd1);
    check("A_floor", {28'd0, floor_out}, 32'd4);
    tick();
    check("A_pend4_clr", {31'd0, pending[3]}, 32'd0);
    check("A_busy_dwell", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check("A_dwell_len", n, 32'd4);

    // ---- floors 2, 7, 9 together ----
    do_reset();
    iss_floor.delete(); iss_cyc.delete();
    call_btn = '0; call_btn[1] = 1'b1; call_btn[6] = 1'b1; call_btn[8] = 1'b1;
    floor_ready = 1'b1;
    tick();
    call_btn = '0;
    run(25);
    check("B_count", iss_floor.size(), 32'd3);
    check("B_first", (iss_floor.size() > 0) ? iss_floor[0] : -1, 32'd2);
    check("B_second", (iss_floor.size() > 1) ? iss_floor[1] : -1, 32'd7);
    check("B_third", (iss_floor.size() > 2) ? iss_floor[2] : -1, 32'd9);
    check("B_gap1", (iss_cyc.size() > 1) ? iss_cyc[1] - iss_cyc[0] : -1, 32'd6);
    check("B_gap2", (iss_cyc.size() > 2) ? iss_cyc[2] - iss_cyc[1] : -1, 32'd6);

    // ---- wrap-around: last served 9, floors 10 and 1 pending ----
    do_reset();
    call_btn = '0; call_btn[8] = 1'b1; floor_ready = 1'b1;
    tick();
    call_btn = '0;
    run(12);
    iss_floor.delete(); iss_cyc.delete();
    call_btn[9] = 1'b1; call_btn[0] = 1'b1;
    tick();
    call_btn = '0;
    run(20);
    check("C_count", iss_floor.size(), 32'd2);
    check("C_first", (iss_floor.size() > 0) ? iss_floor[0] : -1, 32'd10);
    check("C_second", (iss_floor.size() > 1) ? iss_floor[1] : -1, 32'd1);

    // ---- backpressure on floor 3 while 6 and 8 are pressed ----
    do_reset();
    floor_ready = 1'b0;
    call_btn = '0; call_btn[2] = 1'b1;
    tick();
    call_btn = '0;
    wait_valid(10, n);
    check("D_floor", {28'd0, floor_out}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      call_btn = '0; call_btn[5] = 1'b1; call_btn[7] = 1'b1;
      tick();
      check("D_hold_valid", {31'd0, floor_valid}, 32'd1);
      check("D_hold_floor", {28'd0, floor_out}, 32'd3);
    end
    call_btn = '0;
    check("D_pend6", {31'd0, pending[5]}, 32'd1);
    check("D_pend8", {31'd0, pending[7]}, 32'd1);
    floor_ready = 1'b1;
    tick();
    check("D_accept_valid", {31'd0, floor_valid}, 32'd0);
    check("D_accept_clr3", {31'd0, pending[2]}, 32'd0);
    run(25);

    // ---- asynchronous reset mid-OFFER, then held button for floor 5 ----
    do_reset();
    floor_ready = 1'b0;
    call_btn = '0; call_btn[4] = 1'b1; call_btn[1] = 1'b1;
    tick();
    call_btn = '0;
    wait_valid(10, n);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("E_async_valid", {31'd0, floor_valid}, 32'd0);
    check("E_async_pending", {22'd0, pending}, 32'd0);
    check("E_async_floor", {28'd0, floor_out}, 32'd0);
    check("E_async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    call_btn = '0; call_btn[4] = 1'b1; floor_ready = 1'b1;
    tick();
    tick();
    check("E_offer5", {28'd0, floor_out}, 32'd5);
    tick();
    check("E_accepted", {31'd0, floor_valid}, 32'd0);
    check("E_set_wins", {31'd0, pending[4]}, 32'd1);
    call_btn = '0;
    t0 = cyc;
    iss_floor.delete(); iss_cyc.delete();
    wait_valid(15, n);
    check("E_reissue_floor", {28'd0, floor_out}, 32'd5);
    check("E_reissue_delay", cyc - t0, 32'd5);
    run(10);

`ifdef CALL_COUNT_EN
    // ---- accepted-call counter and saturation ----
    do_reset();
    call_btn = '0; call_btn[0] = 1'b1; call_btn[1] = 1'b1; call_btn[2] = 1'b1;
    floor_ready = 1'b1;
    tick();
    call_btn = '0;
    run(25);
    check("F_count3", {16'd0, call_count}, 32'd3);
    #2;
    force dut.r_call_count = 16'hFFFF;
    m_cnt = 65535;
    #1;
    release dut.r_call_count;
    call_btn[3] = 1'b1;
    tick();
    call_btn = '0;
    run(10);
    check("F_saturate", {16'd0, call_count}, 32'h0000FFFF);
`endif

    // ---- randomized traffic checked by the per-cycle compare ----
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 5) == 0)
          call_btn = NF'($urandom) & NF'($urandom);
        else
          call_btn = '0;
        floor_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hall_call_scheduler.md
HALL_CALL_SCHEDULER -- requirements
Module: hall_call_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, default 10, number of served floors; floors are numbered 1..NUM_FLOORS.
REQ-002 Parameter FLOOR_W, default 4, width of the floor number.
REQ-003 Parameter DWELL_CYCLES, default 4, idle cycles after each issued call; legal range 1..255.
REQ-004 Port clk, input, 1, single clock; all state is updated on the rising edge.
REQ-005 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 Port call_btn, input, NUM_FLOORS, hall-call buttons, level-sampled; bit i is floor i+1.
REQ-007 Port floor_out, output, FLOOR_W, floor number offered to the downstream lift controller.
REQ-008 Port floor_valid, output, 1, floor_out holds a valid call.
REQ-009 Port floor_ready, input, 1, downstream accepts floor_out.
REQ-010 Port pending, output, NUM_FLOORS, registered bitmap of outstanding calls.
REQ-011 Port busy, output, 1, high whenever the state is not IDLE.
REQ-012 Port call_count, output, 16, count of accepted calls; present only under CALL_COUNT_EN.

Function
REQ-013 A pending bit shall be set on any edge where its call_btn bit is high.
REQ-014 A pending bit shall be cleared on the edge where its floor is accepted (floor_valid and floor_ready both high).
REQ-015 If set and clear of the same bit coincide on one edge, set shall win and the bit stays 1.
REQ-016 The FSM shall have exactly three states: IDLE, OFFER and DWELL.
REQ-017 IDLE shall move to OFFER when pending is non-zero.
  - On that same edge, floor_out loads the selected floor.
  - floor_valid is registered high in OFFER.
REQ-018 Floor selection shall be round-robin.
  - The search starts at last_served+1 and wraps from NUM_FLOORS to 1.
  - The first pending floor found is selected.
REQ-019 OFFER shall hold floor_out and floor_valid stable until floor_ready is high at an edge.
  - On that edge: clear the pending bit, set last_served to floor_out, and move to DWELL.
  - floor_valid goes low on entering DWELL.
REQ-020 DWELL shall last exactly DWELL_CYCLES cycles, then return to IDLE.
  - Buttons are still captured into pending during DWELL.
REQ-021 Latency: call_btn sampled high at edge N gives floor_valid high after edge N+1, when in IDLE with no other pending floor ahead of it.
REQ-022 floor_out shall never be 0 while floor_valid is high.
REQ-023 floor_ready shall be ignored outside OFFER.
REQ-024 Buttons pressed for the currently offered floor shall not alter floor_out.

Reset
REQ-025 Asserting rst_n low shall immediately force the following, regardless of state, including mid-OFFER:
  - state to IDLE, pending to 0, floor_out to 0;
  - floor_valid, busy, DWELL counter and call_count to 0;
  - last_served to NUM_FLOORS, so the first search starts at floor 1.
REQ-026 After deassertion, operation shall begin on the first clock edge.

Configuration
REQ-027 Macro CALL_COUNT_EN, when defined, shall add port call_count.
  - It increments on each accepted handshake.
  - It saturates at 0xFFFF.
REQ-028 Without CALL_COUNT_EN, the call_count port and its counter logic shall be absent; all other behaviour is identical.

Structure
REQ-029 Shared package lift_pkg shall hold:
  - constants NUM_FLOORS_DEF and FLOOR_W_DEF;
  - the FSM state enum (IDLE, OFFER, DWELL).
REQ-030 Sub-module rr_floor_picker shall be the purely combinational round-robin selector.
  - Inputs: pending and last_served.
  - Outputs: selected floor and an any-pending flag.

Verification
REQ-031 Press call_btn floor 4 for one cycle, floor_ready=1 → floor_valid high two edges later, floor_out=4, pending[3] clears on acceptance, busy drops after 4 DWELL cycles.
REQ-032 Press floors 2, 7 and 9 together, floor_ready=1 → issue order 2, 7, 9, with consecutive valids 6 cycles apart (OFFER + 4 DWELL + IDLE).
REQ-033 With last_served=9 and floors 10 and 1 pending → 10 issued first, then 1 (wrap-around).
REQ-034 Backpressure:
  - Stimulus: floor_ready=0 for 5 cycles in OFFER while other buttons are pressed.
  - Response: floor_out and floor_valid stay stable; new calls appear in pending.
  - Then: the call is accepted on the edge floor_ready rises.
REQ-035 Reset and same-floor button:
  - Stimulus: assert rst_n low mid-OFFER with floor_ready=0.
  - Response: floor_valid and pending go to 0 without waiting for a clock edge.
  - Stimulus: after release, hold call_btn for floor 5 high through acceptance.
  - Response: pending[4] stays set (set wins) and floor 5 is re-issued after DWELL.
REQ-036 With CALL_COUNT_EN defined:
  - Stimulus: 3 accepted calls.
  - Response: call_count=3.
  - Stimulus: force the counter to 0xFFFF, then accept one more call.
  - Response: call_count stays 0xFFFF.
